// File: rtl/pipe_pkg.sv
// Shared pipeline types and default widths for the EX/MEM boundary.
package pipe_pkg;

    localparam int DEFAULT_XLEN         = 32;
    localparam int DEFAULT_RD_W         = 5;
    localparam int DEFAULT_WB_W         = 3;
    localparam int DEFAULT_M_W          = 3;
    localparam int DEFAULT_REGWRITE_BIT = 0;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic                    zero;
        logic [DEFAULT_XLEN-1:0] alu_result;
        logic [DEFAULT_XLEN-1:0] rs2;
        logic [DEFAULT_RD_W-1:0] rd;
        logic [DEFAULT_WB_W-1:0] wb;
        logic [DEFAULT_M_W-1:0]  m;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid absorbs
// one entry of backpressure. Flush squashes both; reset clears everything.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter type payload_t = ex_mem_payload_t
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  payload_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output payload_t out_data
);

    logic     main_valid_r, skid_valid_r;
    payload_t main_r, skid_r;
    logic     accept_s, consume_s;
    logic     main_valid_nxt_s, skid_valid_nxt_s;
    logic     load_main_in_s, load_main_skid_s, load_skid_s;

    // Next-state decode: flush wins, then skid drain, then direct or skid load.
    always_comb begin
        accept_s         = in_valid && !skid_valid_r && !flush;
        consume_s        = main_valid_r && out_ready;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (consume_s && skid_valid_r) begin
            load_main_skid_s = 1'b1;
            main_valid_nxt_s = 1'b1;
            skid_valid_nxt_s = 1'b0;
        end else if (accept_s && (!main_valid_r || consume_s)) begin
            load_main_in_s   = 1'b1;
            main_valid_nxt_s = 1'b1;
        end else if (accept_s) begin
            load_skid_s      = 1'b1;
            skid_valid_nxt_s = 1'b1;
        end else if (consume_s) begin
            main_valid_nxt_s = 1'b0;
        end else begin
            main_valid_nxt_s = main_valid_r;
        end
    end

    // Storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_r       <= '{default: '0};
            skid_r       <= '{default: '0};
        end else begin
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            if (load_main_in_s) begin
                main_r <= in_data;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready  = rst_n && !skid_valid_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_r;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary with handshake, flush, bubble gating and forwarding tap.
// Optional performance counters are built when EX_MEM_PERF_EN is defined.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int XLEN         = DEFAULT_XLEN,
    parameter int RD_W         = DEFAULT_RD_W,
    parameter int WB_W         = DEFAULT_WB_W,
    parameter int M_W          = DEFAULT_M_W,
    parameter int REGWRITE_BIT = DEFAULT_REGWRITE_BIT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WB_W-1:0] in_wb,
    input  logic [M_W-1:0]  in_m,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_zero,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            out_zero,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_writedata,
    output logic [RD_W-1:0] out_rd,
    output logic [WB_W-1:0] out_wb,
    output logic [M_W-1:0]  out_m,
    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            zero;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2;
        logic [RD_W-1:0] rd;
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
    } payload_t;

    payload_t in_payload_s, out_payload_s;
    logic     out_valid_s, in_ready_s;

    // Pack EX results into the buffer payload.
    always_comb begin
        in_payload_s.pc         = in_pc;
        in_payload_s.zero       = in_zero;
        in_payload_s.alu_result = in_alu_result;
        in_payload_s.rs2        = in_rs2;
        in_payload_s.rd         = in_rd;
        in_payload_s.wb         = in_wb;
        in_payload_s.m          = in_m;
    end

    pipe_skid_buf #(.payload_t(payload_t)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_payload_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_payload_s)
    );

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_s;
    assign out_pc         = out_payload_s.pc;
    assign out_zero       = out_payload_s.zero;
    assign out_alu_result = out_payload_s.alu_result;
    assign out_writedata  = out_payload_s.rs2;
    assign out_rd         = out_payload_s.rd;

    // Bubbles carry zeroed control so MEM/WB never write on an empty slot.
    always_comb begin
        if (out_valid_s) begin
            out_wb = out_payload_s.wb;
            out_m  = out_payload_s.m;
        end else begin
            out_wb = {WB_W{1'b0}};
            out_m  = {M_W{1'b0}};
        end
    end

    assign fwd_valid = out_valid_s && out_payload_s.wb[REGWRITE_BIT]
                       && (out_payload_s.rd != {RD_W{1'b0}});
    assign fwd_rd    = out_payload_s.rd;
    assign fwd_data  = out_payload_s.alu_result;

`ifdef EX_MEM_PERF_EN
    logic stall_s, flush_evt_s;

    // With rst_n high, a deasserted in_ready means the skid entry is held.
    assign stall_s     = out_valid_s && !out_ready;
    assign flush_evt_s = flush && (out_valid_s || !in_ready_s);

    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
            if (flush_evt_s && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end else begin
                perf_flush_cnt <= perf_flush_cnt;
            end
        end
    end
`endif

endmodule
